mem_wb_stage: RTL and testbench

//   MEM/WB pipeline stage and writeback unit of the RV32I core. Holds one retiring

---
 rtl/mem_wb_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage of the RV32I core: formats load data, picks the writeback source,
// drives the register-file write port and keeps a 1-entry skid buffer behind the stage register.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_wr_i,
  input  logic [1:0]       mem_wb_sel_i,
  input  logic [2:0]       mem_funct3_i,
  input  logic [XLEN-1:0]  mem_alu_res_i,
  input  logic [XLEN-1:0]  mem_load_data_i,
  input  logic [XLEN-1:0]  mem_pc_plus4_i,
  input  logic             flush_i,
  input  logic             wb_stall_i,
  output logic [4:0]       wr_port_o,
  output logic [XLEN-1:0]  wr_data_o,
  output logic             reg_wr_en_o,
  output logic             fwd_valid_o,
  output logic [4:0]       fwd_rd_o,
  output logic [XLEN-1:0]  fwd_data_o,
  output logic [CNT_W-1:0] instret_o
);

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]      funct3,
                                               input logic [1:0]      off,
                                               input logic [XLEN-1:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [XLEN-1:0]    res;
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res = {{(XLEN-8){byte_s[7]}}, byte_s};
      3'b100:  res = {{(XLEN-8){1'b0}}, byte_s};
      3'b001:  res = {{(XLEN-16){half_s[15]}}, half_s};
      3'b101:  res = {{(XLEN-16){1'b0}}, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [XLEN-1:0] sel_wb(input logic [1:0]      wb_sel,
                                             input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] load,
                                             input logic [XLEN-1:0] link);
    logic [XLEN-1:0] res;
    case (wb_sel)
      2'b01:   res = load;
      2'b10:   res = link;
      default: res = alu;
    endcase
    return res;
  endfunction

  logic             s_valid_q, s_valid_d;
  logic             s_wr_q, s_wr_d;
  logic [4:0]       s_rd_q, s_rd_d;
  logic [XLEN-1:0]  s_data_q, s_data_d;
  logic             k_valid_q, k_valid_d;
  logic             k_wr_q, k_wr_d;
  logic [4:0]       k_rd_q, k_rd_d;
  logic [XLEN-1:0]  k_data_q, k_data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  wb_val;
  logic             commit;
  logic             accept;
  logic             s_writes;

  // Input stage: writeback value is resolved before it is registered
  always_comb begin
    wb_val = sel_wb(mem_wb_sel_i, mem_alu_res_i,
                    fmt_load(mem_funct3_i, mem_alu_res_i[1:0], mem_load_data_i),
                    mem_pc_plus4_i);
    commit = s_valid_q && !wb_stall_i && !flush_i;
    accept = mem_valid_i && mem_ready_o;

    s_valid_d = s_valid_q;
    s_wr_d    = s_wr_q;
    s_rd_d    = s_rd_q;
    s_data_d  = s_data_q;
    k_valid_d = k_valid_q;
    k_wr_d    = k_wr_q;
    k_rd_d    = k_rd_q;
    k_data_d  = k_data_q;

    if (flush_i) begin
      s_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (!s_valid_q || commit) begin
      if (k_valid_q) begin
        s_valid_d = 1'b1;
        s_wr_d    = k_wr_q;
        s_rd_d    = k_rd_q;
        s_data_d  = k_data_q;
        k_valid_d = 1'b0;
      end else begin
        s_valid_d = accept;
        if (accept) begin
          s_wr_d   = mem_reg_wr_i;
          s_rd_d   = mem_rd_i;
          s_data_d = wb_val;
        end
      end
    end else if (accept) begin
      // S is stalled, so the extra beat parks in the skid buffer
      k_valid_d = 1'b1;
      k_wr_d    = mem_reg_wr_i;
      k_rd_d    = mem_rd_i;
      k_data_d  = wb_val;
    end

    instret_d = instret_q + {{(CNT_W-1){1'b0}}, commit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      instret_q <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      k_valid_q <= k_valid_d;
      instret_q <= instret_d;
    end
  end

  // Payload registers carry no reset; every output is gated by the valid flags
  always_ff @(posedge clk) begin
    s_wr_q   <= s_wr_d;
    s_rd_q   <= s_rd_d;
    s_data_q <= s_data_d;
    k_wr_q   <= k_wr_d;
    k_rd_q   <= k_rd_d;
    k_data_q <= k_data_d;
  end

  // Writeback stage: combinational from S
  always_comb begin
    s_writes    = s_valid_q && s_wr_q && (s_rd_q != 5'd0);
    mem_ready_o = !k_valid_q;
    reg_wr_en_o = s_writes && commit;
    wr_port_o   = s_valid_q ? s_rd_q : 5'd0;
    wr_data_o   = s_valid_q ? s_data_q : '0;
    fwd_valid_o = s_writes;
    fwd_rd_o    = s_valid_q ? s_rd_q : 5'd0;
    fwd_data_o  = s_valid_q ? s_data_q : '0;
    instret_o   = instret_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic against a
// queue-based model of the stage (in-order FIFO of at most two retiring beats).
module tb_mem_wb_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_valid_i;
  logic             mem_ready_o;
  logic [4:0]       mem_rd_i;
  logic             mem_reg_wr_i;
  logic [1:0]       mem_wb_sel_i;
  logic [2:0]       mem_funct3_i;
  logic [XLEN-1:0]  mem_alu_res_i;
  logic [XLEN-1:0]  mem_load_data_i;
  logic [XLEN-1:0]  mem_pc_plus4_i;
  logic             flush_i;
  logic             wb_stall_i;
  logic [4:0]       wr_port_o;
  logic [XLEN-1:0]  wr_data_o;
  logic             reg_wr_en_o;
  logic             fwd_valid_o;
  logic [4:0]       fwd_rd_o;
  logic [XLEN-1:0]  fwd_data_o;
  logic [CNT_W-1:0] instret_o;

  mem_wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_rd_i(mem_rd_i), .mem_reg_wr_i(mem_reg_wr_i),
    .mem_wb_sel_i(mem_wb_sel_i), .mem_funct3_i(mem_funct3_i),
    .mem_alu_res_i(mem_alu_res_i), .mem_load_data_i(mem_load_data_i),
    .mem_pc_plus4_i(mem_pc_plus4_i), .flush_i(flush_i), .wb_stall_i(wb_stall_i),
    .wr_port_o(wr_port_o), .wr_data_o(wr_data_o), .reg_wr_en_o(reg_wr_en_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] data;
  } beat_t;

  beat_t           mq[$];
  logic [4:0]      wlog[$];
  longint unsigned m_instret;
  int              checks = 0;
  int              errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] alu,
                                           input logic [31:0] word);
    int unsigned off;
    int unsigned b;
    int unsigned h;
    off = alu % 4;
    b = (word >> (8 * off)) % 256;
    h = (word >> (16 * (off / 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb();
    case (mem_wb_sel_i)
      2'b01:   return ref_load(mem_funct3_i, mem_alu_res_i, mem_load_data_i);
      2'b10:   return mem_pc_plus4_i;
      default: return mem_alu_res_i;
    endcase
  endfunction

  task automatic check_outputs();
    beat_t f;
    logic  has;
    has = (mq.size() > 0);
    f = has ? mq[0] : '0;
    check_val("ready", mem_ready_o, mq.size() < 2);
    check_val("wr_en", reg_wr_en_o, has && !wb_stall_i && !flush_i && f.wr && f.rd != 0);
    check_val("wr_port", wr_port_o, f.rd);
    check_val("wr_data", wr_data_o, f.data);
    check_val("fwd_valid", fwd_valid_o, has && f.wr && f.rd != 0);
    check_val("fwd_rd", fwd_rd_o, f.rd);
    check_val("fwd_data", fwd_data_o, f.data);
    check_val("instret", instret_o, m_instret);
  endtask

  task automatic tick();
    logic  commit;
    logic  acc;
    beat_t nb;
    #1;
    check_outputs();
    if (reg_wr_en_o) wlog.push_back(wr_port_o);
    commit = (mq.size() > 0) && !wb_stall_i && !flush_i;
    acc    = mem_valid_i && (mq.size() < 2);
    nb.rd = mem_rd_i;
    nb.wr = mem_reg_wr_i;
    nb.data = ref_wb();
    if (flush_i) begin
      mq.delete();
    end else begin
      if (commit) begin
        void'(mq.pop_front());
        m_instret++;
      end
      if (acc) mq.push_back(nb);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    mem_valid_i     = 1'b0;
    mem_rd_i        = 5'($urandom);
    mem_reg_wr_i    = 1'($urandom);
    mem_wb_sel_i    = 2'($urandom);
    mem_funct3_i    = 3'($urandom);
    mem_alu_res_i   = $urandom;
    mem_load_data_i = $urandom;
    mem_pc_plus4_i  = $urandom;
  endtask

  task automatic set_beat(input logic [4:0] rd, input logic wr, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] ld, input logic [31:0] pc);
    mem_valid_i     = 1'b1;
    mem_rd_i        = rd;
    mem_reg_wr_i    = wr;
    mem_wb_sel_i    = sel;
    mem_funct3_i    = f3;
    mem_alu_res_i   = alu;
    mem_load_data_i = ld;
    mem_pc_plus4_i  = pc;
  endtask

  task automatic do_reset();
    idle();
    flush_i    = 1'b0;
    wb_stall_i = 1'b0;
    rst_n      = 1'b0;
    mq.delete();
    m_instret = 0;
    #1;
    check_outputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [2:0] lfmt[3]  = '{3'b000, 3'b100, 3'b001};
  logic [31:0] lexp[3] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF};

  initial begin
    rst_n = 1'b1;
    idle();
    flush_i    = 1'b0;
    wb_stall_i = 1'b0;
    #2;
    do_reset();

    // Load formatting: LB / LBU / LH of the same word
    for (int i = 0; i < 3; i++) begin
      set_beat(5'd5, 1'b1, 2'b01, lfmt[i], 32'h1002, 32'h80FF7F01, 32'h0);
      tick();
      idle();
      #1;
      check_val($sformatf("load_fmt%0d", i), wr_data_o, lexp[i]);
      tick();
    end

    // rd=0 never writes but still retires
    do_reset();
    set_beat(5'd0, 1'b1, 2'b00, 3'b0, $urandom, $urandom, $urandom);
    tick();
    idle();
    #1;
    check_val("rd0_no_wr", reg_wr_en_o, 1'b0);
    check_val("rd0_instret0", instret_o, 64'd0);
    tick();
    check_val("rd0_instret1", instret_o, 64'd1);

    // Three beats with a two-cycle stall after the first
    do_reset();
    wlog.delete();
    begin
      int n = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        wb_stall_i = (cyc == 1 || cyc == 2);
        if (n < 3) set_beat(5'(n + 1), 1'b1, 2'b00, 3'b0, 32'hA0 + 32'(n), $urandom, $urandom);
        else idle();
        if (cyc == 2) begin
          #1;
          check_val("t3_ready_drop", mem_ready_o, 1'b0);
        end
        if (mem_valid_i && mem_ready_o) n++;
        tick();
      end
      check_val("t3_all_sent", n, 3);
    end
    wb_stall_i = 1'b0;
    check_val("t3_nwrites", wlog.size(), 3);
    for (int i = 0; i < 3; i++)
      check_val($sformatf("t3_order%0d", i), (i < wlog.size()) ? wlog[i] : 5'h1f, 5'(i + 1));
    check_val("t3_instret", instret_o, 64'd3);

    // Flush with S and K both full
    do_reset();
    set_beat(5'd4, 1'b1, 2'b00, 3'b0, 32'h44, 32'h0, 32'h0);
    tick();
    wb_stall_i = 1'b1;
    set_beat(5'd6, 1'b1, 2'b00, 3'b0, 32'h66, 32'h0, 32'h0);
    tick();
    #1;
    check_val("t4_full", mem_ready_o, 1'b0);
    flush_i = 1'b1;
    wb_stall_i = 1'b0;
    set_beat(5'd8, 1'b1, 2'b00, 3'b0, 32'h88, 32'h0, 32'h0);
    tick();
    flush_i = 1'b0;
    idle();
    #1;
    check_val("t4_ready", mem_ready_o, 1'b1);
    check_val("t4_instret", instret_o, 64'd0);
    check_val("t4_no_wr", reg_wr_en_o, 1'b0);
    tick();

    // PC+4 writeback and forwarding
    set_beat(5'd1, 1'b1, 2'b10, 3'b0, $urandom, $urandom, 32'h104);
    tick();
    idle();
    #1;
    check_val("t5_data", wr_data_o, 32'h104);
    check_val("t5_fwd_valid", fwd_valid_o, 1'b1);
    check_val("t5_fwd_rd", fwd_rd_o, 5'd1);
    tick();

    // Asynchronous reset while S is held by a stall
    wb_stall_i = 1'b1;
    set_beat(5'd9, 1'b1, 2'b00, 3'b0, 32'h99, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_val("t6_wr_en", reg_wr_en_o, 1'b0);
    check_val("t6_port", wr_port_o, 5'd0);
    check_val("t6_data", wr_data_o, 32'd0);
    check_val("t6_fwd", fwd_valid_o, 1'b0);
    check_val("t6_fwd_data", fwd_data_o, 32'd0);
    check_val("t6_instret", instret_o, 64'd0);
    check_val("t6_ready", mem_ready_o, 1'b1);
    mq.delete();
    m_instret = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wb_stall_i = 1'b0;
    set_beat(5'd7, 1'b1, 2'b00, 3'b0, 32'h55, 32'h0, 32'h0);
    tick();
    idle();
    #1;
    check_val("t6_post_en", reg_wr_en_o, 1'b1);
    check_val("t6_post_port", wr_port_o, 5'd7);
    check_val("t6_post_data", wr_data_o, 32'h55);
    tick();
    check_val("t6_post_instret", instret_o, 64'd1);

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(3) != 0)
        set_beat(($urandom_range(4) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), 2'($urandom),
                 3'($urandom), $urandom, $urandom, $urandom);
      else
        idle();
      wb_stall_i = ($urandom_range(2) == 0);
      flush_i    = ($urandom_range(19) == 0);
      tick();
    end
    flush_i    = 1'b0;
    wb_stall_i = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
